bcd_display_scanner: RTL and testbench
======================================

Name: bcd_display_scanner

Overview:
- Time-multiplexed 7-segment display driver; consumer of the cascaded BCD counter chain.
- Takes NUM_DIGITS packed BCD digits, one per counter stage, least significant digit at bits [3:0].
- Scans the digits one at a time onto a common segment bus with per-digit anode selects.
- Performs BCD-to-segment decoding, decimal-point routing and optional leading-zero blanking.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 2..8.
- REFRESH_DIV, 50000, clock cycles each digit stays selected; minimum 2.
- ACTIVE_LOW, 1, 1 = anodes and segments are driven low-active; 0 = high-active.
- BLANK_LEADING, 1, 1 = blank leading zeros; 0 = show all digits.

Ports:
- clk, input, 1, system clock; all state changes on rising edge.
- reset, input, 1, synchronous active-high reset.
- enable, input, 1, display on; when low all anodes and segments are inactive.
- digits, input, 4*NUM_DIGITS, packed BCD; digit k at bits [4k+3:4k]; digit 0 is least significant.
- dp_in, input, NUM_DIGITS, decimal point request per digit.
- an, output, NUM_DIGITS, registered one-hot anode select (polarity per ACTIVE_LOW).
- seg, output, 7, registered segments; seg[0]=a … seg[6]=g (polarity per ACTIVE_LOW).
- dp, output, 1, registered decimal point (polarity per ACTIVE_LOW).
- scan_idx, output, clog2(NUM_DIGITS), index of the digit currently being loaded; used for debug and verification.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - prescaler=0, scan_idx=0.
  - an, seg and dp are all inactive: all 1s if ACTIVE_LOW, else all 0s.
  - Reset asserted mid-scan returns to this state on the next edge, regardless of enable.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 every cycle, independent of enable.
  - On the edge where prescaler==REFRESH_DIV-1: prescaler←0 and scan_idx←scan_idx+1.
  - scan_idx wraps from NUM_DIGITS-1 to 0.
  - Each index is held for exactly REFRESH_DIV cycles; one frame = NUM_DIGITS*REFRESH_DIV cycles.
- Output register:
  - Loads every edge from the current scan_idx, digits, dp_in and enable sampled at that edge.
  - Latency is 1 cycle: an reflects index i on the edge after scan_idx becomes i.
  - Input changes appear on seg one cycle later, with no frame snapshot.
- Anode: one-hot bit scan_idx active when enable=1; all inactive when enable=0.
- Decode (logical, before the polarity inversion; bits listed g..a):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110.
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - Codes 10..15 (invalid BCD) decode to all segments off; the anode is still driven.
- Leading-zero blanking (BLANK_LEADING=1):
  - Digit k is blanked (segments off) if digit k and all digits above k are 0.
  - Digit 0 is never blanked, so the value 0 displays "0".
  - The anode of a blanked digit stays active.
- dp: logical dp = dp_in[scan_idx] when enable=1, else 0. dp is not affected by blanking.
- Polarity: when ACTIVE_LOW=1, an, seg and dp are bitwise inverted after all logic above.
- enable toggling: takes effect on the next edge, with no change to scan timing.

Test Plan (REFRESH_DIV=4, NUM_DIGITS=4, ACTIVE_LOW=1):
1. Reset for 2 cycles, then release with enable=1 and digits=16'h1234.
   - During reset: an=4'b1111, seg=7'h7F.
   - First edge after release: an=4'b1110, seg=~7'b1100110 (digit "4").
   - Anode advances every 4 cycles: 1101, 1011, 0111, then wraps to 1110 at cycle 16.
2. digits=16'h0070, BLANK_LEADING=1, sweep one full frame.
   - Digit 3 and digit 2: seg=7'h7F, with their anodes active.
   - Digit 1: "7" = ~7'b0000111.
   - Digit 0: "0" = ~7'b0111111.
3. digits=16'h0000 -> only digit 0 shows "0"; digits 1..3 blanked. Repeat with BLANK_LEADING=0 -> all four digits show "0".
4. digits=16'h00A5 -> digit 1 (code 10) gives seg=7'h7F; digit 0 shows "5". dp_in=4'b0010 -> dp=0 only while an=1101.
5. Deassert enable mid-frame -> next edge an=4'hF, seg=7'h7F, dp=1, while scan_idx keeps advancing. Reassert enable -> outputs resume with the correct digit for the current scan_idx.
6. Assert reset while scan_idx=2 and prescaler=2 -> next edge scan_idx=0, prescaler=0, all outputs inactive. After release, digit 0 is held for a full 4 cycles.

Source files
------------

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 7-segment scanner for packed BCD digits.
// Decodes, blanks leading zeros and routes decimal points per digit.
module bcd_display_scanner #(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter int ACTIVE_LOW    = 1,
  parameter int BLANK_LEADING = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [4*NUM_DIGITS-1:0]       digits,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [6:0]                    seg,
  output logic                          dp,
  output logic [$clog2(NUM_DIGITS)-1:0] scan_idx
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IMAX = IW'(NUM_DIGITS - 1);
  localparam logic INV = (ACTIVE_LOW != 0);
  localparam logic BLANK = (BLANK_LEADING != 0);

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic [3:0]            cur;
  logic                  upper_nz;
  logic                  blank;
  logic [NUM_DIGITS-1:0] an_l;
  logic [6:0]            seg_l;
  logic                  dp_l;

  // Segment bits are g..a, logical (active-high) sense.
  function automatic logic [6:0] dec7(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == PMAX) begin
      presc_d = '0;
      idx_d   = (idx_q == IMAX) ? '0 : idx_q + 1'b1;
    end
  end

  always_comb begin
    cur      = '0;
    upper_nz = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (IW'(k) == idx_q)
        cur = digits[4*k +: 4];
      // Any nonzero digit at or above the current one keeps it lit.
      if (k >= int'(idx_q) && digits[4*k +: 4] != 4'd0)
        upper_nz = 1'b1;
    end
    blank = BLANK && (idx_q != '0) && !upper_nz;
    an_l  = enable ? (NUM_DIGITS'(1) << idx_q) : '0;
    seg_l = (enable && !blank) ? dec7(cur) : '0;
    dp_l  = enable & dp_in[idx_q];
    an_d  = an_l ^ {NUM_DIGITS{INV}};
    seg_d = seg_l ^ {7{INV}};
    dp_d  = dp_l ^ INV;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      idx_q   <= '0;
      an_q    <= {NUM_DIGITS{INV}};
      seg_q   <= {7{INV}};
      dp_q    <= INV;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an       = an_q;
  assign seg      = seg_q;
  assign dp       = dp_q;
  assign scan_idx = idx_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Bench for bcd_display_scanner: cycle-count reference model plus
// directed literal checks and a randomized soak.
module tb_bcd_display_scanner;

  localparam int N  = 4;
  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] digits;
  logic [3:0]  dp_in;

  logic [3:0]  an, an_nb;
  logic [6:0]  seg, seg_nb;
  logic        dp, dp_nb;
  logic [1:0]  sidx, sidx_nb;

  int checks = 0;
  int errors = 0;

  logic [6:0] cap_seg[4];
  logic [6:0] cap_nb[4];
  logic       cap_dp[4];

  always #5 clk = ~clk;

  bcd_display_scanner #(
    .NUM_DIGITS(N), .REFRESH_DIV(RD),
    .ACTIVE_LOW(1), .BLANK_LEADING(1)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .digits(digits), .dp_in(dp_in),
    .an(an), .seg(seg), .dp(dp), .scan_idx(sidx)
  );

  bcd_display_scanner #(
    .NUM_DIGITS(N), .REFRESH_DIV(RD),
    .ACTIVE_LOW(1), .BLANK_LEADING(0)
  ) dut_nb (
    .clk(clk), .reset(reset), .enable(enable),
    .digits(digits), .dp_in(dp_in),
    .an(an_nb), .seg(seg_nb), .dp(dp_nb), .scan_idx(sidx_nb)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int v);
    logic [6:0] t[10];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return (v < 10) ? t[v] : 7'h00;
  endfunction

  // Reference: the scan position is purely a function of edges since reset.
  int  cyc   = 0;
  bit  armed = 0;

  always @(posedge clk) begin
    automatic bit         r  = reset;
    automatic bit         en = enable;
    automatic int         dv = int'(digits);
    automatic logic [3:0] pv = dp_in;
    automatic logic [3:0] e_an = 4'hF;
    automatic logic [6:0] e_seg = 7'h7F;
    automatic logic [6:0] e_nb = 7'h7F;
    automatic logic       e_dp = 1'b1;
    automatic int         e_idx;
    if (r) begin
      armed = 1;
      cyc   = 0;
    end else if (armed) begin
      automatic int idx = (cyc / RD) % N;
      automatic int d   = (dv >> (4 * idx)) & 15;
      automatic bit bl  = (idx > 0) && ((dv >> (4 * idx)) == 0);
      if (en) begin
        e_an  = ~(4'(1) << idx);
        e_seg = ~(bl ? 7'h00 : seg_of(d));
        e_nb  = ~seg_of(d);
        e_dp  = ~pv[idx];
      end
      cyc++;
    end
    e_idx = (cyc / RD) % N;
    #1;
    if (armed) begin
      chk("model_an", an, e_an);
      chk("model_seg", seg, e_seg);
      chk("model_dp", dp, e_dp);
      chk("model_idx", sidx, e_idx);
      chk("model_an_nb", an_nb, e_an);
      chk("model_seg_nb", seg_nb, e_nb);
      chk("model_dp_nb", dp_nb, e_dp);
    end
  end

  task automatic capture();
    repeat (N * RD) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (an[i] == 1'b0) begin
          cap_seg[i] = seg;
          cap_dp[i]  = dp;
        end
        if (an_nb[i] == 1'b0) cap_nb[i] = seg_nb;
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    digits = 16'h1234;
    dp_in  = 4'b0000;
    repeat (2) @(negedge clk);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);

    reset = 1'b0;
    @(negedge clk);
    chk("first_an", an, 4'b1110);
    chk("first_seg", seg, 7'b0011001);
    repeat (3) @(negedge clk);
    chk("hold_an", an, 4'b1110);
    @(negedge clk);
    chk("an_d1", an, 4'b1101);
    repeat (4) @(negedge clk);
    chk("an_d2", an, 4'b1011);
    repeat (4) @(negedge clk);
    chk("an_d3", an, 4'b0111);
    repeat (4) @(negedge clk);
    chk("an_wrap", an, 4'b1110);

    digits = 16'h0070;
    @(negedge clk);
    capture();
    chk("blank_d3", cap_seg[3], 7'h7F);
    chk("blank_d2", cap_seg[2], 7'h7F);
    chk("seven_d1", cap_seg[1], 7'b1111000);
    chk("zero_d0", cap_seg[0], 7'b1000000);

    digits = 16'h0000;
    @(negedge clk);
    capture();
    chk("z_d0", cap_seg[0], 7'b1000000);
    chk("z_d1", cap_seg[1], 7'h7F);
    chk("z_d3", cap_seg[3], 7'h7F);
    for (int i = 0; i < N; i++)
      chk("z_nb", cap_nb[i], 7'b1000000);

    digits = 16'h00A5;
    dp_in  = 4'b0010;
    @(negedge clk);
    capture();
    chk("inv_d1", cap_seg[1], 7'h7F);
    chk("five_d0", cap_seg[0], 7'b0010010);
    chk("dp_d1", cap_dp[1], 1'b0);
    chk("dp_d0", cap_dp[0], 1'b1);

    repeat (2) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("dis_an", an, 4'hF);
    chk("dis_seg", seg, 7'h7F);
    chk("dis_dp", dp, 1'b1);
    repeat (5) @(negedge clk);
    enable = 1'b1;
    repeat (3) @(negedge clk);

    begin
      automatic int n = 0;
      while (sidx == 2'd2 && n < 40) begin @(negedge clk); n++; end
      while (sidx != 2'd2 && n < 40) begin @(negedge clk); n++; end
      chk("wait_idx2", sidx, 2'd2);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_idx", sidx, 2'd0);
    chk("mid_rst_an", an, 4'hF);
    chk("mid_rst_seg", seg, 7'h7F);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_an", an, 4'b1110);
    repeat (3) @(negedge clk);
    chk("post_rst_hold", an, 4'b1110);
    @(negedge clk);
    chk("post_rst_adv", an, 4'b1101);

    repeat (800) begin
      automatic int k = $urandom_range(0, 4);
      digits = 16'($urandom) & (16'hFFFF >> (4 * k));
      dp_in  = 4'($urandom);
      enable = ($urandom % 8) != 0;
      reset  = ($urandom % 150) == 0;
      @(negedge clk);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
